// File: rtl/hvac_pkg.sv
// Shared types and default timing constants for the HVAC actuator controller.
package hvac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10,
    ST_REST = 2'b11
  } hvac_state_e;

  localparam int unsigned DEF_MIN_ON   = 8;
  localparam int unsigned DEF_MIN_OFF  = 6;
  localparam int unsigned DEF_FAN_TAIL = 4;
  localparam int unsigned DEF_CNT_W    = 8;

  function automatic logic is_active(input hvac_state_e s);
    return (s == ST_HEAT) || (s == ST_COOL);
  endfunction

endpackage

// File: rtl/hvac_dwell_cnt.sv
// Saturating up-counter with synchronous clear; measures time spent in a state.
module hvac_dwell_cnt
  import hvac_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count up, hold at all-ones, restart from zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r != {CNT_W{1'b1}}) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hvac_actuator_ctrl.sv
// Heater/cooler/fan sequencer with minimum on-time, anti-short-cycle lockout
// and a fan run-on tail. All outputs are registered from the next state.
module hvac_actuator_ctrl
  import hvac_pkg::*;
#(
  parameter int unsigned MIN_ON   = DEF_MIN_ON,
  parameter int unsigned MIN_OFF  = DEF_MIN_OFF,
  parameter int unsigned FAN_TAIL = DEF_FAN_TAIL,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic heat_req,
  input  logic cool_req,
  output logic heater_on,
  output logic cooler_on,
  output logic fan_on,
  output logic busy,
  output logic conflict
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] FAN_LOAD = CNT_W'(FAN_TAIL);

  hvac_state_e      state_r, state_next_s;
  logic [CNT_W-1:0] dwell_s;
  logic             dwell_clr_s;
  logic [CNT_W-1:0] fan_cnt_r, fan_cnt_next_s;
  logic             valid_heat_s, valid_cool_s;
  logic             heater_next_s, cooler_next_s, fan_next_s, busy_next_s;
  logic             heater_on_r, cooler_on_r, fan_on_r, busy_r, conflict_r;

  // Simultaneous requests cancel each other out.
  assign valid_heat_s = heat_req & ~cool_req;
  assign valid_cool_s = cool_req & ~heat_req;
  assign dwell_clr_s  = (state_next_s != state_r);

  hvac_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dwell_clr_s),
    .count (dwell_s)
  );

  // State register; power-up starts in the lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_REST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_heat_s) begin
          state_next_s = ST_HEAT;
        end else if (valid_cool_s) begin
          state_next_s = ST_COOL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HEAT: begin
        if ((dwell_s >= ON_LAST) && !valid_heat_s) begin
          state_next_s = ST_REST;
        end else begin
          state_next_s = ST_HEAT;
        end
      end
      ST_COOL: begin
        if ((dwell_s >= ON_LAST) && !valid_cool_s) begin
          state_next_s = ST_REST;
        end else begin
          state_next_s = ST_COOL;
        end
      end
      ST_REST: begin
        if (dwell_s != OFF_LAST) begin
          state_next_s = ST_REST;
        end else if (valid_heat_s) begin
          state_next_s = ST_HEAT;
        end else if (valid_cool_s) begin
          state_next_s = ST_COOL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_REST;
    endcase
  end

  // Output decode from the next state, plus the fan tail countdown.
  always_comb begin
    fan_cnt_next_s = fan_cnt_r;
    if (is_active(state_r) && (state_next_s == ST_REST)) begin
      fan_cnt_next_s = FAN_LOAD;
    end else if (is_active(state_next_s)) begin
      fan_cnt_next_s = {CNT_W{1'b0}};
    end else if (fan_cnt_r != {CNT_W{1'b0}}) begin
      fan_cnt_next_s = fan_cnt_r - CNT_W'(1);
    end else begin
      fan_cnt_next_s = fan_cnt_r;
    end
    heater_next_s = (state_next_s == ST_HEAT);
    cooler_next_s = (state_next_s == ST_COOL);
    busy_next_s   = (state_next_s == ST_REST);
    fan_next_s    = is_active(state_next_s) || (fan_cnt_next_s != {CNT_W{1'b0}});
  end

  // Output and fan tail registers; reset kills actuators at once, no tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_cnt_r   <= {CNT_W{1'b0}};
      heater_on_r <= 1'b0;
      cooler_on_r <= 1'b0;
      fan_on_r    <= 1'b0;
      busy_r      <= 1'b1;
      conflict_r  <= 1'b0;
    end else begin
      fan_cnt_r   <= fan_cnt_next_s;
      heater_on_r <= heater_next_s;
      cooler_on_r <= cooler_next_s;
      fan_on_r    <= fan_next_s;
      busy_r      <= busy_next_s;
      conflict_r  <= heat_req & cool_req;
    end
  end

  assign heater_on = heater_on_r;
  assign cooler_on = cooler_on_r;
  assign fan_on    = fan_on_r;
  assign busy      = busy_r;
  assign conflict  = conflict_r;

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// Randomised + directed bench for hvac_actuator_ctrl against a timer-based
// behavioural model of the actuator sequencing rules.
module tb_hvac_actuator_ctrl;

  localparam int MIN_ON   = 8;
  localparam int MIN_OFF  = 6;
  localparam int FAN_TAIL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic heat_req = 1'b0;
  logic cool_req = 1'b0;
  logic heater_on, cooler_on, fan_on, busy, conflict;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  hvac_actuator_ctrl #(
    .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .FAN_TAIL(FAN_TAIL), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .heat_req(heat_req), .cool_req(cool_req),
    .heater_on(heater_on), .cooler_on(cooler_on), .fan_on(fan_on),
    .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // act: 0 none, 1 heat, 2 cool; on_cyc: completed on-cycles;
  // rest_left: remaining lockout cycles; tail: remaining fan run-on cycles.
  typedef struct {
    int act;
    int on_cyc;
    int rest_left;
    int tail;
    bit conf;
  } mdl_t;

  mdl_t m = '{act: 0, on_cyc: 0, rest_left: MIN_OFF, tail: 0, conf: 1'b0};

  function automatic mdl_t mdl_step(input mdl_t cur, input logic h, input logic c);
    mdl_t n;
    bit vh, vc, own;
    n  = cur;
    vh = h & ~c;
    vc = c & ~h;
    n.conf = h & c;
    if (cur.act != 0) begin
      n.on_cyc = cur.on_cyc + 1;
      own = (cur.act == 1) ? vh : vc;
      if (n.on_cyc >= MIN_ON && !own) begin
        n.act = 0;
        n.rest_left = MIN_OFF;
        n.tail = FAN_TAIL;
      end
    end else begin
      if (cur.tail > 0) n.tail = cur.tail - 1;
      if (cur.rest_left > 0) n.rest_left = cur.rest_left - 1;
      if (n.rest_left == 0 && (vh || vc)) begin
        n.act = vh ? 1 : 2;
        n.on_cyc = 0;
        n.tail = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{act: 0, on_cyc: 0, rest_left: MIN_OFF, tail: 0, conf: 1'b0};
    else        m <= mdl_step(m, heat_req, cool_req);
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_heater", heater_on, m.act == 1);
      cmp("model_cooler", cooler_on, m.act == 2);
      cmp("model_busy", busy, (m.act == 0) && (m.rest_left > 0));
      cmp("model_fan", fan_on, (m.act != 0) || (m.tail > 0));
      cmp("model_conflict", conflict, m.conf);
      cmp("exclusive", heater_on & cooler_on, 1'b0);
    end
  end

  // Releases reset (called ~2 units after a negedge) and checks the 6-cycle lockout.
  task automatic lockout_check(input string tag);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < MIN_OFF; i++) begin
      cmp({tag, "_busy"}, busy, 1'b1);
      cmp({tag, "_heater_low"}, heater_on, 1'b0);
      @(negedge clk); #3;
    end
    cmp({tag, "_heater_rise"}, heater_on, 1'b1);
    cmp({tag, "_fan_rise"}, fan_on, 1'b1);
    cmp({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int hc, cc, fc, bc, xc, both, last_h, first_c;
    int r;

    // Reset state, then power-up lockout with heat already demanded.
    heat_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    cmp("rst_heater", heater_on, 1'b0);
    cmp("rst_cooler", cooler_on, 1'b0);
    cmp("rst_fan", fan_on, 1'b0);
    cmp("rst_conflict", conflict, 1'b0);
    cmp("rst_busy", busy, 1'b1);
    chk_en = 1'b1;
    #1;
    lockout_check("pwrup");
    heat_req = 1'b0;
    repeat (30) @(negedge clk);
    #3;

    // Two-cycle heat pulse from IDLE.
    hc = 0; fc = 0; bc = 0;
    heat_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #3;
      if (i == 1) heat_req = 1'b0;
      hc += int'(heater_on); fc += int'(fan_on); bc += int'(busy);
    end
    cmp_int("pulse_heater_cycles", hc, 8);
    cmp_int("pulse_fan_cycles", fc, 12);
    cmp_int("pulse_busy_cycles", bc, 6);

    // Cooling held for 20 cycles.
    hc = 0; cc = 0;
    cool_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #3;
      if (i == 0) cmp("cool_rise_lag", cooler_on, 1'b1);
      if (i == 20) cmp("cool_fall_lag", cooler_on, 1'b0);
      if (i == 19) cool_req = 1'b0;
      hc += int'(heater_on); cc += int'(cooler_on);
    end
    cmp_int("cool_cycles", cc, 20);
    cmp_int("cool_heater_cycles", hc, 0);

    // Heat for 10 cycles, then switch straight to cool.
    hc = 0; both = 0; last_h = -1; first_c = -1;
    heat_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #3;
      if (i == 9) begin heat_req = 1'b0; cool_req = 1'b1; end
      if (heater_on) begin hc++; last_h = i; end
      if (cooler_on && first_c < 0) first_c = i;
      if (heater_on && cooler_on) both++;
    end
    cmp_int("switch_heater_cycles", hc, 10);
    cmp_int("switch_dead_time", first_c - last_h - 1, 6);
    cmp_int("switch_both_high", both, 0);
    cool_req = 1'b0;
    repeat (40) @(negedge clk);
    #3;

    // Both requests for 3 cycles in IDLE.
    xc = 0; hc = 0; cc = 0; fc = 0;
    heat_req = 1'b1; cool_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #3;
      if (i == 2) begin heat_req = 1'b0; cool_req = 1'b0; end
      xc += int'(conflict); hc += int'(heater_on); cc += int'(cooler_on); fc += int'(fan_on);
    end
    cmp_int("idle_conflict_cycles", xc, 3);
    cmp_int("idle_conflict_act", hc + cc + fc, 0);

    // Conflict arriving after the minimum on-time has elapsed in HEAT.
    heat_req = 1'b1;
    repeat (8) begin @(negedge clk); #3; end
    cool_req = 1'b1;
    @(negedge clk); #3;
    cmp("heat_conflict_flag", conflict, 1'b1);
    cmp("heat_conflict_drop", heater_on, 1'b0);
    cmp("heat_conflict_rest", busy, 1'b1);
    cmp("heat_conflict_fan", fan_on, 1'b1);
    heat_req = 1'b0; cool_req = 1'b0;
    repeat (20) @(negedge clk);
    #3;

    // Reset pulled mid-HEAT, away from any clock edge.
    heat_req = 1'b1;
    repeat (4) begin @(negedge clk); #3; end
    cmp("midheat_on", heater_on, 1'b1);
    rst_n = 1'b0;
    #1;
    cmp("midrst_heater", heater_on, 1'b0);
    cmp("midrst_fan", fan_on, 1'b0);
    cmp("midrst_busy", busy, 1'b1);
    @(negedge clk); #2;
    lockout_check("rerst");
    heat_req = 1'b0;

    // Randomised run with held requests and occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #3;
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 9);
        heat_req = (r < 4) || (r == 9);
        cool_req = (r >= 4 && r < 7) || (r == 9);
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
